axi4_lite_sram_slave: RTL and testbench
=======================================

Name: axi4_lite_sram_slave

Overview:
- AXI4-Lite responder (slave) backed by an internal word-addressed SRAM array.
- Serves as the far end for the core's load/store and fetch AXI4-Lite masters in standalone and unit-level simulation, replacing DPI-backed memory.
- Read and write channels are independent; each supports one outstanding transaction, with configurable response latency and SLVERR on out-of-range accesses.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- MEM_WORDS, 1024, number of 32-bit words (power of two, 16..65536).
- READ_LATENCY, 1, extra cycles between AR handshake and RVALID (0..15).
- WRITE_LATENCY, 0, extra cycles between write commit and BVALID (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs are registered.
  - Reset values: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=0.
  - Readies rise on the first clk edge after rst deasserts.
  - SRAM contents are not reset.
- Reset mid-operation: aborts both FSMs immediately, drops valids/readies, discards any held AW/W. A partially captured write never commits.
- Address decode: idx = (addr - BASE_ADDR) >> 2.
  - addr[1:0] is ignored. The slave returns full unshifted words; the master does lane alignment.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS. Otherwise the response is SLVERR (2'b10); OKAY is 2'b00.
- Write FSM states: W_IDLE, W_HALF, W_DELAY, W_RESP.
  - W_IDLE: awready=1, wready=1.
    - AW and W may handshake in the same cycle or in either order.
    - Only one of them handshakes -> capture it, go to W_HALF. That channel's ready drops; the other's stays 1.
  - W_HALF -> W_DELAY on the missing handshake.
  - Commit: the SRAM is written on the edge of the later handshake, per byte lane where wstrb[i]=1.
    - Out of range: no write.
    - wstrb=0: no write, response OKAY.
  - W_DELAY counts WRITE_LATENCY cycles (0 -> skip straight to W_RESP). BVALID rises WRITE_LATENCY+1 cycles after the commit edge.
  - W_RESP: bvalid=1, bresp held stable until bready. On the handshake edge -> W_IDLE with awready=wready=1 on the next edge.
- Read FSM states: R_IDLE, R_DELAY, R_RESP.
  - R_IDLE: arready=1. On the AR handshake, latch the index and range flag, drop arready.
  - RVALID rises READ_LATENCY+1 cycles after the AR handshake edge.
  - rdata is sampled from the SRAM at the edge rvalid rises. Out of range: rdata=32'h0, rresp=SLVERR.
  - rvalid/rdata/rresp are held stable until rready; the handshake returns to R_IDLE.
- Collision: the SRAM has one write port and one read port. A read sampled on the same edge as a commit to the same word returns the NEW data (write-first bypass).
- Channels never block each other; simultaneous read and write handshakes are both accepted.
- bvalid/rvalid never deassert without a handshake; payloads never change while valid.

Optional Feature:
- AXI_SLV_RAND_DELAY_EN defined: a 16-bit Galois LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - On entering W_DELAY or R_DELAY, lfsr[1:0] cycles (0..3) are added to the configured latency.
  - In W_IDLE/R_IDLE, readies are deasserted on cycles where lfsr[2]=1.
  - Deterministic under reset, for backpressure testing.
- Undefined: latencies are exactly as configured; readies follow the FSMs only.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Write/read FSM state encodings.
  - AXI address/data/strobe widths.
- Sub-module axi_lite_lfsr16: enable, 16-bit state output, reset to seed. Instantiated only under AXI_SLV_RAND_DELAY_EN.

Test Plan:
- Write 0x1234_5678 to 0x8000_0010 with wstrb=4'hF, AW and W in the same cycle, bready=1 -> bvalid 1 cycle later (WRITE_LATENCY=0), bresp=00. Then read 0x8000_0010 -> rvalid 2 cycles after the AR handshake, rdata=0x1234_5678, rresp=00.
- Write with W two cycles before AW, wdata=0xAABB_CCDD, wstrb=4'b0101, onto 0x1234_5678 -> wready low while waiting; read returns 0x12BB_56DD.
- Read 0x8000_1000 (out of range for 1024 words) -> rresp=10, rdata=0; write there -> bresp=10, the SRAM is unchanged at all 1024 words.
- Hold rready=0 for 5 cycles with rvalid=1 -> rdata/rresp stable and arready=0 throughout. Meanwhile a write completes normally.
- Same-cycle commit to 0x8000_0020 (0xCAFE_F00D) and read sample of the same word (READ_LATENCY tuned) -> rdata=0xCAFE_F00D.
- Assert rst for 1 cycle while in W_HALF holding AW=0x8000_0004 -> all valids/readies 0 immediately; subsequent read of 0x8000_0004 returns the prior value.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants, FSM state encodings and byte-lane helper
// used by the SRAM-backed responder and its LFSR delay source.
package axi_lite_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_HALF  = 2'd1;
    localparam logic [1:0] W_DELAY = 2'd2;
    localparam logic [1:0] W_RESP  = 2'd3;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_DELAY = 2'd1;
    localparam logic [1:0] R_RESP  = 2'd2;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wbeat_t;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_lfsr16.sv
// 16-bit Galois LFSR used as a deterministic delay/backpressure source.
// Only present when AXI_SLV_RAND_DELAY_EN is defined.
`ifdef AXI_SLV_RAND_DELAY_EN
module axi_lite_lfsr16
    import axi_lite_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en) state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LFSR_SEED;
        else     state_q <= state_d;
    end

    assign state = state_q;

endmodule
`endif

// File: rtl/axi4_lite_sram_slave.sv
// AXI4-Lite responder over a word-addressed SRAM, one outstanding read and write.
// AXI_SLV_RAND_DELAY_EN adds LFSR-driven extra latency and idle-ready stalls.
//
// state   | meaning
// W_IDLE  | awready=wready=1, waiting for AW and/or W
// W_HALF  | one of AW/W captured, waiting for the other
// W_DELAY | write committed, counting down response latency
// W_RESP  | bvalid held until bready
// R_IDLE  | arready=1, waiting for AR
// R_DELAY | address latched, counting down read latency
// R_RESP  | rvalid/rdata/rresp held until rready
module axi4_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int unsigned MEM_WORDS     = 1024,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned WRITE_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    localparam int          IDX_W  = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN   = 32'(4 * MEM_WORDS);
    localparam logic [4:0]  WR_LAT = 5'(WRITE_LATENCY);
    localparam logic [4:0]  RD_LAT = 5'(READ_LATENCY);

    logic [4:0] lat_extra;
    logic       stall;

`ifdef AXI_SLV_RAND_DELAY_EN
    logic [15:0] lfsr;

    axi_lite_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr)
    );

    assign lat_extra = {3'b000, lfsr[1:0]};
    assign stall     = lfsr[2];
`else
    assign lat_extra = 5'd0;
    assign stall     = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    logic [1:0]        w_state_q, w_state_d;
    logic              awready_q, awready_d;
    logic              wready_q,  wready_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic [4:0]        w_cnt_q,   w_cnt_d;
    logic [ADDR_W-1:0] waddr_q,   waddr_d;
    wbeat_t            wbeat_q,   wbeat_d;

    logic [1:0]        r_state_q, r_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [4:0]        r_cnt_q,   r_cnt_d;
    logic [IDX_W-1:0]  ridx_q,    ridx_d;
    logic              rok_q,     rok_d;

    logic              aw_hs, w_hs, ar_hs;
    logic              wr_en, wr_ok, ar_ok;
    logic [ADDR_W-1:0] wr_addr, wr_off, ar_off;
    logic [IDX_W-1:0]  wr_idx, ar_idx;
    wbeat_t            wr_beat;
    logic [DATA_W-1:0] rd_word;

    assign aw_hs = awvalid && awready_q;
    assign w_hs  = wvalid  && wready_q;
    assign ar_hs = arvalid && arready_q;

    // Offsets below BASE_ADDR wrap to large values, so one compare covers both bounds
    assign wr_off = wr_addr - BASE_ADDR;
    assign wr_ok  = wr_off < SPAN;
    assign wr_idx = wr_off[IDX_W+1:2];
    assign ar_off = araddr - BASE_ADDR;
    assign ar_ok  = ar_off < SPAN;
    assign ar_idx = ar_off[IDX_W+1:2];

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        w_cnt_d   = w_cnt_q;
        waddr_d   = waddr_q;
        wbeat_d   = wbeat_q;
        wr_en     = 1'b0;
        wr_addr   = awaddr;
        wr_beat   = '{data: wdata, strb: wstrb};
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_en = 1'b1;
                end else if (aw_hs) begin
                    waddr_d   = awaddr;
                    awready_d = 1'b0;
                    w_state_d = W_HALF;
                end else if (w_hs) begin
                    wbeat_d   = '{data: wdata, strb: wstrb};
                    wready_d  = 1'b0;
                    w_state_d = W_HALF;
                end else begin
                    awready_d = ~stall;
                    wready_d  = ~stall;
                end
            end
            W_HALF: begin
                if (aw_hs) begin
                    wr_en   = 1'b1;
                    wr_beat = wbeat_q;
                end else if (w_hs) begin
                    wr_en   = 1'b1;
                    wr_addr = waddr_q;
                end
            end
            W_DELAY: begin
                if (w_cnt_q == 5'd0) begin
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q - 5'd1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (wr_en) begin
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
            w_cnt_d   = WR_LAT + lat_extra;
            w_state_d = W_DELAY;
        end
    end

    // Write-first bypass when a commit lands on the word being sampled
    always_comb begin
        rd_word = mem_q[ridx_q];
        if (wr_en && wr_ok && (wr_idx == ridx_q))
            rd_word = byte_merge(rd_word, wr_beat.data, wr_beat.strb);
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        r_cnt_d   = r_cnt_q;
        ridx_d    = ridx_q;
        rok_d     = rok_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ridx_d    = ar_idx;
                    rok_d     = ar_ok;
                    arready_d = 1'b0;
                    r_cnt_d   = RD_LAT + lat_extra;
                    r_state_d = R_DELAY;
                end else begin
                    arready_d = ~stall;
                end
            end
            R_DELAY: begin
                if (r_cnt_q == 5'd0) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = rok_q ? rd_word : '0;
                    rresp_d   = rok_q ? RESP_OKAY : RESP_SLVERR;
                    r_state_d = R_RESP;
                end else begin
                    r_cnt_d = r_cnt_q - 5'd1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok)
            mem_q[wr_idx] <= byte_merge(mem_q[wr_idx], wr_beat.data, wr_beat.strb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            w_cnt_q   <= 5'd0;
            waddr_q   <= '0;
            wbeat_q   <= '0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            r_cnt_q   <= 5'd0;
            ridx_q    <= '0;
            rok_q     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            w_cnt_q   <= w_cnt_d;
            waddr_q   <= waddr_d;
            wbeat_q   <= wbeat_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            r_cnt_q   <= r_cnt_d;
            ridx_q    <= ridx_d;
            rok_q     <= rok_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_sram_slave.sv
// Self-checking bench for axi4_lite_sram_slave: directed table, corner sequences,
// randomized traffic against a word-array reference model.
module tb_axi4_lite_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 1024;
    localparam int          RL    = 1;
    localparam int          WL    = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 clk = ~clk;

    axi4_lite_sram_slave #(
        .BASE_ADDR     (BASE),
        .MEM_WORDS     (WORDS),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] model [WORDS];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * WORDS);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        if (!in_rng(a)) return;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        model[widx(a)] = (model[widx(a)] & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        return in_rng(a) ? model[widx(a)] : 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return in_rng(a) ? 2'b00 : 2'b10;
    endfunction

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int bhold,
                             output logic [1:0] resp, output int lat);
        int t = 0;
        int aw_start = (lead > 0) ? lead : 0;
        int w_start  = (lead < 0) ? -lead : 0;
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        logic [1:0] r0;
        while (!(aw_done && w_done) && t < 100) begin
            if (aw_done != w_done)
                chk("half_ready", {30'd0, awready, wready}, aw_done ? 32'd1 : 32'd2);
            awaddr  = a;
            awvalid = !aw_done && (t >= aw_start);
            wdata   = d;
            wstrb   = s;
            wvalid  = !w_done && (t >= w_start);
            hs_aw   = awvalid && awready;
            hs_w    = wvalid && wready;
            tick();
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done  = 1;
            t++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("aw_w_timeout", {31'd0, aw_done && w_done}, 32'd1);
        lat = 0;
        while (!bvalid && lat < 50) begin
            tick();
            lat++;
        end
        resp = bresp;
        r0   = bresp;
        for (int k = 0; k < bhold; k++) begin
            tick();
            chk("b_hold_valid", {31'd0, bvalid}, 32'd1);
            chk("b_hold_resp", {30'd0, bresp}, {30'd0, r0});
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b_drop", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] a, input int rhold,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        int t = 0;
        logic [31:0] d0;
        logic [1:0]  r0;
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && t < 100) begin
            tick();
            t++;
        end
        chk("ar_wait", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin
            tick();
            lat++;
        end
        data = rdata;
        resp = rresp;
        d0   = rdata;
        r0   = rresp;
        for (int k = 0; k < rhold; k++) begin
            tick();
            chk("r_hold_valid", {31'd0, rvalid}, 32'd1);
            chk("r_hold_data", rdata, d0);
            chk("r_hold_resp", {30'd0, rresp}, {30'd0, r0});
            chk("r_hold_arready", {31'd0, arready}, 32'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("r_drop", {31'd0, rvalid}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          lead;
        logic [1:0]  eb;
        logic [31:0] ra;
        logic [31:0] er;
        logic [1:0]  err;
    } vec_t;

    vec_t vt [6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp, rresp_v;
        logic [31:0] rd, a, d, old;
        logic [3:0]  s;
        int          lat, lat2, t;

        vt[0] = '{32'h8000_0010, 32'h1234_5678, 4'hF, 0,  2'b00, 32'h8000_0010, 32'h1234_5678, 2'b00};
        vt[1] = '{32'h8000_0010, 32'hAABB_CCDD, 4'h5, 2,  2'b00, 32'h8000_0010, 32'h12BB_56DD, 2'b00};
        vt[2] = '{32'h8000_1000, 32'h5555_AAAA, 4'hF, 0,  2'b10, 32'h8000_1000, 32'h0000_0000, 2'b10};
        vt[3] = '{32'h7FFF_FFFC, 32'h0F0F_0F0F, 4'hF, -1, 2'b10, 32'h7FFF_FFFC, 32'h0000_0000, 2'b10};
        vt[4] = '{32'h8000_0FFF, 32'h0BAD_BEEF, 4'hF, -2, 2'b00, 32'h8000_0FFC, 32'h0BAD_BEEF, 2'b00};
        vt[5] = '{32'h8000_0013, 32'hFFFF_FFFF, 4'h0, 1,  2'b00, 32'h8000_0011, 32'h12BB_56DD, 2'b00};

        #2;
        chk("rst_handshake", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'd0);
        chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        tick();
        rst = 1'b0;
        chk("rst_release_ready", {29'd0, awready, wready, arready}, 32'd0);
        tick();
        chk("first_edge_ready", {29'd0, awready, wready, arready}, 32'd7);

        for (int i = 0; i < WORDS; i++) begin
            d = $urandom;
            axi_write(BASE + 32'(4 * i), d, 4'hF, 0, 0, resp, lat);
            model_write(BASE + 32'(4 * i), d, 4'hF);
            chk("fill_bresp", {30'd0, resp}, 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            axi_write(vt[i].wa, vt[i].wd, vt[i].ws, vt[i].lead, 0, resp, lat);
            model_write(vt[i].wa, vt[i].wd, vt[i].ws);
            chk("vec_bresp", {30'd0, resp}, {30'd0, vt[i].eb});
            chk("vec_wlat", 32'(lat), 32'(WL + 1));
            axi_read(vt[i].ra, 0, rd, rresp_v, lat);
            chk("vec_rdata", rd, vt[i].er);
            chk("vec_rresp", {30'd0, rresp_v}, {30'd0, vt[i].err});
            chk("vec_rlat", 32'(lat), 32'(RL + 1));
        end

        // read held 5 cycles while an independent write completes
        d = 32'h3C3C_A5A5;
        fork
            begin
                logic [31:0] rd_f;
                logic [1:0]  rr_f;
                int          lat_f;
                axi_read(BASE + 32'h40, 5, rd_f, rr_f, lat_f);
                chk("hold_rdata", rd_f, model[16]);
                chk("hold_rresp", {30'd0, rr_f}, 32'd0);
            end
            begin
                axi_write(BASE + 32'h44, d, 4'hF, 0, 0, resp, lat2);
                chk("hold_bresp", {30'd0, resp}, 32'd0);
                chk("hold_wlat", 32'(lat2), 32'(WL + 1));
            end
        join
        model_write(BASE + 32'h44, d, 4'hF);

        // commit and read sample on the same edge
        t = 0;
        while (!(arready && awready && wready) && t < 20) begin
            tick();
            t++;
        end
        chk("coll_idle", {29'd0, arready, awready, wready}, 32'd7);
        araddr  = BASE + 32'h20;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        awaddr  = BASE + 32'h20;
        awvalid = 1'b1;
        wdata   = 32'hCAFE_F00D;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        model_write(BASE + 32'h20, 32'hCAFE_F00D, 4'hF);
        chk("coll_rvalid", {31'd0, rvalid}, 32'd1);
        chk("coll_rdata", rdata, 32'hCAFE_F00D);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("coll_bvalid", {31'd0, bvalid}, 32'd1);
        chk("coll_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        tick();

        // reset while holding AW in W_HALF; the partial write must never commit
        old = model[1];
        awaddr  = BASE + 32'h4;
        awvalid = 1'b1;
        t = 0;
        while (!awready && t < 20) begin
            tick();
            t++;
        end
        tick();
        awvalid = 1'b0;
        chk("whalf_ready", {30'd0, awready, wready}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_handshake", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'd0);
        wdata  = 32'hDEAD_BEEF;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        tick();
        rst    = 1'b0;
        wvalid = 1'b0;
        tick();
        chk("midrst_ready", {29'd0, awready, wready, arready}, 32'd7);
        axi_read(BASE + 32'h4, 0, rd, rresp_v, lat);
        chk("midrst_rdata", rd, old);
        chk("midrst_rresp", {30'd0, rresp_v}, 32'd0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'(4 * $urandom_range(1, 64));
                1:       a = BASE + 32'(4 * WORDS) + 32'($urandom_range(0, 255));
                default: a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 4) - 2, $urandom_range(0, 2), resp, lat);
                chk("rnd_bresp", {30'd0, resp}, {30'd0, model_resp(a)});
                chk("rnd_wlat", 32'(lat), 32'(WL + 1));
                model_write(a, d, s);
            end else begin
                axi_read(a, $urandom_range(0, 2), rd, rresp_v, lat);
                chk("rnd_rdata", rd, model_rdata(a));
                chk("rnd_rresp", {30'd0, rresp_v}, {30'd0, model_resp(a)});
                chk("rnd_rlat", 32'(lat), 32'(RL + 1));
            end
        end

        // out-of-range write must leave every word untouched
        axi_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0, resp, lat);
        chk("oor_bresp", {30'd0, resp}, 32'd2);
        for (int i = 0; i < WORDS; i++) begin
            axi_read(BASE + 32'(4 * i), 0, rd, rresp_v, lat);
            chk("scan_rdata", rd, model[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
